// File: rtl/imm_narrow.sv
// imm_narrow: finds a 16-bit immediate and a 2-bit extender opcode that
// rebuild a 32-bit constant exactly. One candidate encoding is tried per
// TRY cycle, in order 00, 01, 10, 11. Values with no encoding are counted
// in a saturating failure counter.
//
// Optional feature: define IMM_NARROW_SHIFT_EN to enable candidate 11
// (sign-extend then shift left by 2). When it is undefined, only
// candidates 00..10 are tried.
module imm_narrow #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_found,
  output logic [15:0]      out_imm,
  output logic [1:0]       out_eop,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRY = 2'd1, DONE = 2'd2} state_t;

`ifdef IMM_NARROW_SHIFT_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  state_t      state;
  state_t      state_next;
  logic [1:0]  idx;
  logic [31:0] value;
  logic        hit;
  logic [15:0] cand_imm;
  logic        last;

  assign last = (idx == LAST_IDX);

  // Test the single candidate selected by idx against the captured value.
  always_comb begin
    hit      = 1'b0;
    cand_imm = value[15:0];
    case (idx)
      2'd0: hit = (value[31:15] == '0) || (value[31:15] == '1);
      2'd1: hit = (value[31:16] == '0);
      2'd2: begin
        hit      = (value[15:0] == '0);
        cand_imm = value[31:16];
      end
      default: begin
`ifdef IMM_NARROW_SHIFT_EN
        hit      = (value[1:0] == 2'b00) &&
                   ((value[31:17] == '0) || (value[31:17] == '1));
        cand_imm = value[17:2];
`else
        hit      = 1'b0;
`endif
      end
    endcase
  end

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept, search the candidates, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = TRY;
      TRY:     if (hit || last) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture the value, step idx, load the result and count failures.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= 2'd0;
      value     <= 32'd0;
      out_found <= 1'b0;
      out_imm   <= 16'd0;
      out_eop   <= 2'd0;
      fail_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            value <= in_value;
            idx   <= 2'd0;
          end
        end
        TRY: begin
          if (hit) begin
            out_found <= 1'b1;
            out_imm   <= cand_imm;
            out_eop   <= idx;
          end else if (last) begin
            out_found <= 1'b0;
            out_imm   <= 16'd0;
            out_eop   <= 2'd0;
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
